// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
//   Shared types and constants for the APB master arbiter slice.
//   arb_state_t : IDLE (no command), ISSUE (TRANS pulse), WAIT (transfer active)
//   APB_AW/APB_DW : APB address/data widths
//   NUM_REQ_MIN/NUM_REQ_MAX : supported requester count range
// ----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_AW      = 32;
    localparam int APB_DW      = 32;
    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// ----------------------------------------------------------------------------
// apb_master_arbiter_if
//   Command port of the shared APB_Master plus the APB bus signals the
//   arbiter observes to detect transfer completion.
//   modport master : arbiter side (drives TRANS/READ/WRITE, addresses, wdata;
//                    observes read data, PENABLE, PREADY, PSLVERR)
//   modport slave  : APB_Master side (the mirror image)
// ----------------------------------------------------------------------------
interface apb_master_arbiter_if;
    import apb_pkg::*;

    logic              TRANS;
    logic              READ;
    logic              WRITE;
    logic [APB_AW-1:0] APB_WRITE_PADDR;
    logic [APB_AW-1:0] APB_READ_PADDR;
    logic [APB_DW-1:0] APB_WRITE_DATA;
    logic [APB_DW-1:0] APB_READ_DATA_OUT;
    logic              PENABLE;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output TRANS, READ, WRITE, APB_WRITE_PADDR, APB_READ_PADDR, APB_WRITE_DATA,
        input  APB_READ_DATA_OUT, PENABLE, PREADY, PSLVERR
    );

    modport slave (
        input  TRANS, READ, WRITE, APB_WRITE_PADDR, APB_READ_PADDR, APB_WRITE_DATA,
        output APB_READ_DATA_OUT, PENABLE, PREADY, PSLVERR
    );

endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The search starts at ptr and wraps;
//   the first requester found wins.
//   req    : request vector
//   ptr    : highest-priority index for this pick
//   gnt    : one-hot grant (all zero when req is zero)
//   gnt_id : binary index of the winner (0 when req is zero)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    int idx;

    // Scan from the lowest priority to the highest so the last hit,
    // i.e. the one closest to ptr, overwrites the earlier ones.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        gnt    = '0;
        gnt_id = '0;
        idx    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// ----------------------------------------------------------------------------
// apb_master_arbiter
//   Shares one APB_Master among NUM_REQ requesters with round-robin
//   arbitration, sequences its TRANS/READ/WRITE command inputs, holds the
//   command stable until PENABLE & PREADY, and returns read data / PSLVERR to
//   the owning requester one cycle after completion.
//   PCLK, PRESETn        : clock, asynchronous active-low reset
//   req_valid/write/addr/wdata : requester commands (slice i = requester i)
//   req_ready            : one-hot pulse, command i taken at this edge
//   rsp_valid/rdata/err  : one-hot response pulse with read data and error
//   apb                  : command port of the APB_Master + observed bus
//   busy_o               : a command is outstanding
//   timeout_o            : sticky, a WAIT lasted TIMEOUT_CYC cycles
// ----------------------------------------------------------------------------
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [APB_AW*NUM_REQ-1:0] req_addr,
    input  logic [APB_DW*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [APB_DW-1:0]         rsp_rdata,
    output logic                      rsp_err,
    apb_master_arbiter_if.master      apb,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     ptr_q;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]     gnt_id;

    logic              cmd_vld_q;
    logic              cmd_write_q;
    logic [APB_AW-1:0] cmd_addr_q;
    logic [APB_DW-1:0] cmd_wdata_q;
    logic [IW-1:0]     cmd_owner_q;

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [APB_DW-1:0]  rsp_rdata_q;
    logic               rsp_err_q;
    logic               timeout_q;

    logic done;
    logic any_req;
    logic grant;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign done    = (state_q == WAIT) & apb.PENABLE & apb.PREADY;
    assign any_req = |req_valid;
    // A new command is taken from IDLE, or on the completion cycle of the
    // current one so the bus goes ACCESS -> SETUP without an idle cycle.
    assign grant   = any_req & ((state_q == IDLE) | done);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done && !any_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command register and round-robin pointer: loaded only on a grant,
    // so a requester that drops req_valid before req_ready loses nothing.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ptr_q       <= '0;
            cmd_vld_q   <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_owner_q <= '0;
        end else if (grant) begin
            ptr_q       <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            cmd_vld_q   <= 1'b1;
            cmd_write_q <= req_write[gnt_id];
            cmd_addr_q  <= req_addr[int'(gnt_id)*APB_AW +: APB_AW];
            cmd_wdata_q <= req_wdata[int'(gnt_id)*APB_DW +: APB_DW];
            cmd_owner_q <= gnt_id;
        end else if (done) begin
            cmd_vld_q   <= 1'b0;
        end
    end

    // Response pulse one cycle after completion; data and error are zero
    // outside that pulse, and writes always return zero data.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= done ? (NUM_REQ'(1) << cmd_owner_q) : '0;
            rsp_rdata_q <= (done && !cmd_write_q) ? apb.APB_READ_DATA_OUT : '0;
            rsp_err_q   <= done & apb.PSLVERR;
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_tmo
            localparam int            CW    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

            logic [CW-1:0] cnt_q;

            // Cleared in ISSUE (the only way into WAIT from outside) and on
            // every done, counts WAIT cycles, saturates at LIMIT.
            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    cnt_q     <= '0;
                    timeout_q <= 1'b0;
                end else if ((state_q == ISSUE) || done) begin
                    cnt_q     <= '0;
                end else if ((state_q == WAIT) && (cnt_q != LIMIT)) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == LIMIT) timeout_q <= 1'b1;
                end
            end
        end else begin : g_no_tmo
            assign timeout_q = 1'b0;
        end
    endgenerate

    assign req_ready           = grant ? gnt : '0;
    assign apb.TRANS           = (state_q == ISSUE) | (done & any_req);
    assign apb.READ            = cmd_vld_q & ~cmd_write_q;
    assign apb.WRITE           = cmd_vld_q & cmd_write_q;
    assign apb.APB_READ_PADDR  = cmd_addr_q;
    assign apb.APB_WRITE_PADDR = cmd_addr_q;
    assign apb.APB_WRITE_DATA  = cmd_wdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy_o    = (state_q != IDLE);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_master_arbiter
//   Directed bench for apb_master_arbiter (NUM_REQ=4, TIMEOUT_CYC=8) with a
//   small APB_Master/slave model: TRANS -> SETUP -> ACCESS, PREADY after
//   ws extra ACCESS cycles (or held low), read data = address ^ 0x5A5A_0000
//   unless a fixed value is selected.
// ----------------------------------------------------------------------------
module tb_apb_master_arbiter;

    localparam int NR = 4;

    typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACCESS} mst_t;

    typedef struct {
        logic [NR-1:0] vec;
        logic [31:0]   rdata;
        logic          err;
        int            cyc;
    } rsp_t;

    logic              PCLK;
    logic              PRESETn;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [32*NR-1:0]  req_addr;
    logic [32*NR-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy_o;
    logic              timeout_o;

    apb_master_arbiter_if apb();

    apb_master_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(8)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    // ---------------- APB master / slave model ----------------
    mst_t        mst;
    int          acc_cnt;
    int          ws;
    bit          hold;
    bit          err_flag;
    bit          fix_en;
    logic [31:0] fix_data;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            mst     <= M_IDLE;
            acc_cnt <= 0;
        end else begin
            case (mst)
                M_IDLE:   if (apb.TRANS) mst <= M_SETUP;
                M_SETUP:  begin mst <= M_ACCESS; acc_cnt <= 0; end
                M_ACCESS: begin
                    if (apb.PREADY) mst <= apb.TRANS ? M_SETUP : M_IDLE;
                    else            acc_cnt <= acc_cnt + 1;
                end
                default:  mst <= M_IDLE;
            endcase
        end
    end

    assign apb.PENABLE           = (mst == M_ACCESS);
    assign apb.PREADY            = (mst == M_ACCESS) && (acc_cnt >= ws) && !hold;
    assign apb.PSLVERR           = apb.PREADY && err_flag;
    assign apb.APB_READ_DATA_OUT = fix_en ? fix_data : (apb.APB_READ_PADDR ^ 32'h5A5A_0000);

    // ---------------- monitor (samples on the falling edge) ----------------
    int            cyc;
    int            trans_cnt;
    int            pen_cnt;
    logic [1:0]    psel_seen;
    logic [NR-1:0] gnt_q[$];
    int            gnt_cyc_q[$];
    rsp_t          rsp_q[$];

    always @(negedge PCLK) begin
        cyc <= cyc + 1;
        if (apb.TRANS)   trans_cnt <= trans_cnt + 1;
        if (apb.PENABLE) pen_cnt   <= pen_cnt + 1;
        if (mst == M_SETUP)
            psel_seen <= (apb.READ ? apb.APB_READ_PADDR[31] : apb.APB_WRITE_PADDR[31]) ? 2'b10 : 2'b01;
        if (req_ready != '0) begin
            gnt_q.push_back(req_ready);
            gnt_cyc_q.push_back(cyc);
        end
        if (rsp_valid != '0) rsp_q.push_back('{rsp_valid, rsp_rdata, rsp_err, cyc});
    end

    // ---------------- checking ----------------
    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int id, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        req_write[id]          = wr;
        req_addr[32*id +: 32]  = addr;
        req_wdata[32*id +: 32] = data;
    endtask

    // Present one command, wait for its req_ready, withdraw after the grant edge.
    task automatic send(input int id, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
        bit ok;
        ok = 0;
        @(posedge PCLK); #1;
        set_cmd(id, wr, addr, data);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK); #1;
            if (req_ready[id]) begin ok = 1; break; end
        end
        check({tag, "_gnt"}, 32'(ok), 32'd1);
        @(posedge PCLK); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string tag, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_q.size() >= target) begin ok = 1; break; end
            @(negedge PCLK); #1;
        end
        check({tag, "_rsp_seen"}, 32'(ok), 32'd1);
    endtask

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          g0, r0, t0, p0;
        bit          ok;
        logic [31:0] a;
        logic [NR-1:0] e;

        n_checks = 0; n_fail = 0;
        cyc = 0; trans_cnt = 0; pen_cnt = 0; psel_seen = '0;
        ws = 0; hold = 0; err_flag = 0; fix_en = 0; fix_data = '0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK); #1;

        // ---- reset state ----
        check("rst_trans",   32'(apb.TRANS), 0);
        check("rst_read",    32'(apb.READ),  0);
        check("rst_write",   32'(apb.WRITE), 0);
        check("rst_busy",    32'(busy_o),    0);
        check("rst_timeout", 32'(timeout_o), 0);
        check("rst_rsp",     32'(rsp_valid), 0);
        check("rst_addr",    apb.APB_WRITE_PADDR, 0);

        // ---- contention: all four valid, rr from ptr=0 ----
        for (int i = 0; i < NR; i++)
            set_cmd(i, (i % 2) == 0, 32'h1000_0000 + 32'(i) * 32'h100, 32'hC0DE_0000 + 32'(i));
        g0 = gnt_q.size(); r0 = rsp_q.size(); t0 = trans_cnt;
        @(posedge PCLK); #1;
        req_valid = '1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK); #1;
            if (gnt_q.size() >= g0 + 5) begin ok = 1; break; end
        end
        check("rr_five_grants", 32'(ok), 1);
        @(posedge PCLK); #1;
        req_valid = '0;
        wait_rsp(r0 + 5, "rr", ok);
        if (ok) begin
            for (int k = 0; k < 5; k++) begin
                e = NR'(1) << (k % NR);
                a = 32'h1000_0000 + 32'(k % NR) * 32'h100;
                check($sformatf("rr_gnt%0d", k),   32'(gnt_q[g0+k]), 32'(e));
                check($sformatf("rr_owner%0d", k), 32'(rsp_q[r0+k].vec), 32'(e));
                check($sformatf("rr_rdata%0d", k), rsp_q[r0+k].rdata, ((k % 2) == 1) ? (a ^ 32'h5A5A_0000) : 32'h0);
                check($sformatf("rr_err%0d", k),   32'(rsp_q[r0+k].err), 0);
            end
            check("rr_grant_span", 32'(gnt_cyc_q[g0+4] - gnt_cyc_q[g0]), 9);
            check("rr_total_span", 32'(rsp_q[r0+4].cyc - gnt_cyc_q[g0]), 12);
        end
        check("rr_trans_pulses", 32'(trans_cnt - t0), 5);
        check("rr_no_extra_rsp", 32'(rsp_q.size() - r0), 5);

        // ---- single write, cycle by cycle ----
        t0 = trans_cnt;
        @(posedge PCLK); #1;
        set_cmd(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5);
        req_valid[0] = 1'b1;
        @(negedge PCLK); #1;
        check("wr_ready",      32'(req_ready), 32'b0001);
        check("wr_idle_trans", 32'(apb.TRANS), 0);
        @(posedge PCLK); #1;
        req_valid[0] = 1'b0;
        @(negedge PCLK); #1;
        check("wr_issue_trans", 32'(apb.TRANS), 1);
        check("wr_issue_write", 32'(apb.WRITE), 1);
        check("wr_issue_read",  32'(apb.READ),  0);
        check("wr_paddr",       apb.APB_WRITE_PADDR, 32'h0000_0010);
        check("wr_pwdata",      apb.APB_WRITE_DATA,  32'hA5A5_A5A5);
        @(negedge PCLK); #1;
        check("wr_setup_trans", 32'(apb.TRANS),   0);
        check("wr_setup_pen",   32'(apb.PENABLE), 0);
        check("wr_setup_write", 32'(apb.WRITE),   1);
        @(negedge PCLK); #1;
        check("wr_access_pen",   32'(apb.PENABLE), 1);
        check("wr_access_write", 32'(apb.WRITE),   1);
        check("wr_access_trans", 32'(apb.TRANS),   0);
        @(negedge PCLK); #1;
        check("wr_rsp_valid", 32'(rsp_valid), 32'b0001);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_rsp_err",   32'(rsp_err), 0);
        check("wr_done_write",32'(apb.WRITE), 0);
        check("wr_done_busy", 32'(busy_o), 0);
        check("wr_trans_once",32'(trans_cnt - t0), 1);

        // ---- read with two wait states ----
        ws = 2; fix_en = 1; fix_data = 32'h1234_5678;
        p0 = pen_cnt; r0 = rsp_q.size();
        send(2, 1'b0, 32'h8000_0004, 32'h0, "rd");
        wait_rsp(r0 + 1, "rd", ok);
        if (ok) begin
            check("rd_owner", 32'(rsp_q[r0].vec), 32'b0100);
            check("rd_rdata", rsp_q[r0].rdata, 32'h1234_5678);
            check("rd_err",   32'(rsp_q[r0].err), 0);
        end
        check("rd_penable_cycles", 32'(pen_cnt - p0), 3);
        check("rd_psel",           32'(psel_seen), 32'b10);
        ws = 0; fix_en = 0;

        // ---- slave error on a read, then a clean transfer ----
        err_flag = 1;
        r0 = rsp_q.size();
        send(1, 1'b0, 32'h0000_0020, 32'h0, "err");
        wait_rsp(r0 + 1, "err", ok);
        if (ok) begin
            check("err_owner", 32'(rsp_q[r0].vec), 32'b0010);
            check("err_flag",  32'(rsp_q[r0].err), 1);
            check("err_rdata", rsp_q[r0].rdata, 32'h0000_0020 ^ 32'h5A5A_0000);
        end
        err_flag = 0;
        send(1, 1'b1, 32'h0000_0024, 32'h0BAD_F00D, "err2");
        wait_rsp(r0 + 2, "err2", ok);
        if (ok) begin
            check("err2_owner", 32'(rsp_q[r0+1].vec), 32'b0010);
            check("err2_flag",  32'(rsp_q[r0+1].err), 0);
        end

        // ---- timeout: PREADY held low ----
        hold = 1;
        r0 = rsp_q.size();
        @(posedge PCLK); #1;
        set_cmd(3, 1'b1, 32'h0000_0030, 32'h3333_3333);
        req_valid[3] = 1'b1;
        @(negedge PCLK); #1;
        check("tmo_ready", 32'(req_ready), 32'b1000);
        @(posedge PCLK); #1;
        req_valid[3] = 1'b0;
        repeat (9) @(negedge PCLK);
        #1;
        check("tmo_not_yet", 32'(timeout_o), 0);
        check("tmo_busy",    32'(busy_o),    1);
        @(negedge PCLK); #1;
        check("tmo_set", 32'(timeout_o), 1);
        @(posedge PCLK); #1;
        hold = 0;
        wait_rsp(r0 + 1, "tmo", ok);
        if (ok) begin
            check("tmo_owner", 32'(rsp_q[r0].vec), 32'b1000);
            check("tmo_err",   32'(rsp_q[r0].err), 0);
        end
        check("tmo_sticky", 32'(timeout_o), 1);

        // ---- reset in ACCESS ----
        hold = 1;
        send(1, 1'b0, 32'h0000_0040, 32'h0, "mid");
        repeat (3) @(negedge PCLK);
        #1;
        check("mid_in_access", 32'(apb.PENABLE), 1);
        r0 = rsp_q.size();
        PRESETn = 1'b0;
        #1;
        check("mid_busy",    32'(busy_o),    0);
        check("mid_read",    32'(apb.READ),  0);
        check("mid_trans",   32'(apb.TRANS), 0);
        check("mid_timeout", 32'(timeout_o), 0);
        check("mid_rsp",     32'(rsp_valid), 0);
        hold = 0;
        @(posedge PCLK); @(posedge PCLK); #1;
        PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);
        #1;
        check("mid_no_rsp", 32'(rsp_q.size() - r0), 0);
        // ptr was 2 before reset; a reset pointer picks 1 over 3.
        @(posedge PCLK); #1;
        set_cmd(1, 1'b1, 32'h0000_0050, 32'h1111_1111);
        set_cmd(3, 1'b1, 32'h0000_0060, 32'h3333_3333);
        req_valid = 4'b1010;
        @(negedge PCLK); #1;
        check("mid_ptr_zero", 32'(req_ready), 32'b0010);
        @(posedge PCLK); #1;
        req_valid[1] = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK); #1;
            if (req_ready[3]) begin ok = 1; break; end
        end
        check("mid_second_gnt", 32'(ok), 1);
        @(posedge PCLK); #1;
        req_valid[3] = 1'b0;
        wait_rsp(r0 + 2, "mid", ok);
        if (ok) begin
            check("mid_rsp0", 32'(rsp_q[r0].vec),   32'b0010);
            check("mid_rsp1", 32'(rsp_q[r0+1].vec), 32'b1000);
        end

        repeat (2) @(negedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
